// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the button event decoder.
// BTN_DOUBLE_CLICK_EN adds the double-click wait states to state_t.
package btn_event_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_LONG   = 2'd2,
    EV_DOUBLE = 2'd3
  } event_code_t;

`ifdef BTN_DOUBLE_CLICK_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    DBL_HELD  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;
`endif

  // Timer width wide enough for the larger of the two terminal counts.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module btn_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced presses into short / long / double-click event pulses.
// Double-click detection is compiled in when BTN_DOUBLE_CLICK_EN is defined.
module btn_event_decoder
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES  = 250_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             db_tick_i,
  input  logic             db_level_i,
  input  logic             clr_cnt_i,
  output logic             short_o,
  output logic             long_o,
  output logic             double_o,
  output logic [1:0]       event_code_o,
  output logic [CNT_W-1:0] press_cnt_o
);

  localparam int unsigned   TW        = timer_width(LONG_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          short_c, long_c, double_c, accept_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state and timer; every terminal timer value forces an exit.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      IDLE: begin
        if (db_tick_i) state_d = PRESSED;
      end
      PRESSED: begin
        if (!db_level_i) begin
`ifdef BTN_DOUBLE_CLICK_EN
          state_d = WAIT2;
`else
          state_d = IDLE;
`endif
        end else if (timer_q == LONG_LAST) begin
          state_d = LONG_HELD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      LONG_HELD: begin
        if (!db_level_i) state_d = IDLE;
      end
`ifdef BTN_DOUBLE_CLICK_EN
      WAIT2: begin
        if (db_tick_i) begin
          state_d = DBL_HELD;
        end else if (timer_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DBL_HELD: begin
        if (!db_level_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Event and press-accept decode; a tick in WAIT2 wins over gap expiry.
  always_comb begin
    short_c  = 1'b0;
    long_c   = 1'b0;
    double_c = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE: accept_c = db_tick_i;
      PRESSED: begin
        if (db_level_i && (timer_q == LONG_LAST)) long_c = 1'b1;
`ifndef BTN_DOUBLE_CLICK_EN
        if (!db_level_i) short_c = 1'b1;
`endif
      end
`ifdef BTN_DOUBLE_CLICK_EN
      WAIT2: begin
        if (db_tick_i) begin
          double_c = 1'b1;
          accept_c = 1'b1;
        end else if (timer_q == GAP_LAST) begin
          short_c = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      short_o      <= 1'b0;
      long_o       <= 1'b0;
      event_code_o <= EV_NONE;
    end else begin
      short_o <= short_c;
      long_o  <= long_c;
      if (long_c)       event_code_o <= EV_LONG;
      else if (short_c) event_code_o <= EV_SHORT;
      else if (double_c) event_code_o <= EV_DOUBLE;
    end
  end

`ifdef BTN_DOUBLE_CLICK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) double_o <= 1'b0;
    else         double_o <= double_c;
  end
`else
  assign double_o = 1'b0;
`endif

  btn_sat_counter #(.CNT_W(CNT_W)) u_press_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (accept_c),
    .clr   (clr_cnt_i),
    .count (press_cnt_o)
  );

endmodule

// File: tb/tb_btn_event_decoder.sv
// Table-driven bench for btn_event_decoder (LONG=100, GAP=40, CNT_W=3);
// expectations follow BTN_DOUBLE_CLICK_EN when it is defined.
module tb_btn_event_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, level, clr;
  logic       short_p, long_p, dbl_p;
  logic [1:0] ev_code;
  logic [2:0] press_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int n; bit tick; bit lvl; bit clr;
    bit sh; bit lg; bit db; int code; int cnt;
  } row_t;

  typedef struct { bit sh; bit lg; bit db; int code; int cnt; } exp_t;

  row_t rows[$];
  exp_t sb[$];

  btn_event_decoder #(.LONG_CYCLES(100), .GAP_CYCLES(40), .CNT_W(3)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .db_tick_i    (tick),
    .db_level_i   (level),
    .clr_cnt_i    (clr),
    .short_o      (short_p),
    .long_o       (long_p),
    .double_o     (dbl_p),
    .event_code_o (ev_code),
    .press_cnt_o  (press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic void add(int n, bit t, bit l, bit c, bit sh, bit lg, bit db, int code, int cnt);
    row_t r;
    r.n = n; r.tick = t; r.lvl = l; r.clr = c;
    r.sh = sh; r.lg = lg; r.db = db; r.code = code; r.cnt = cnt;
    rows.push_back(r);
  endfunction

  function automatic void fill();
`ifdef BTN_DOUBLE_CLICK_EN
    // double click: second tick 10 cycles after release
    add(1, 1,1,0, 0,0,0, 0,1);
    add(19,0,1,0, 0,0,0, 0,1);
    add(1, 0,0,0, 0,0,0, 0,1);
    add(9, 0,0,0, 0,0,0, 0,1);
    add(1, 1,1,0, 0,0,1, 3,2);
    add(1, 0,1,0, 0,0,0, 3,2);
    add(1, 0,0,0, 0,0,0, 3,2);
    // short reported 40 edges after release
    add(1, 1,1,0, 0,0,0, 3,3);
    add(19,0,1,0, 0,0,0, 3,3);
    add(1, 0,0,0, 0,0,0, 3,3);
    add(39,0,0,0, 0,0,0, 3,3);
    add(1, 0,0,0, 1,0,0, 1,3);
    // tick on the gap-expiry edge becomes a double
    add(1, 1,1,0, 0,0,0, 1,4);
    add(5, 0,1,0, 0,0,0, 1,4);
    add(1, 0,0,0, 0,0,0, 1,4);
    add(39,0,0,0, 0,0,0, 1,4);
    add(1, 1,1,0, 0,0,1, 3,5);
    add(1, 0,0,0, 0,0,0, 3,5);
    // long press
    add(1, 1,1,0, 0,0,0, 3,6);
    add(99,0,1,0, 0,0,0, 3,6);
    add(1, 0,1,0, 0,1,0, 2,6);
    add(1, 0,0,0, 0,0,0, 2,6);
    // clear coinciding with an accepted press
    add(1, 1,1,1, 0,0,0, 2,0);
    add(1, 0,0,0, 0,0,0, 2,0);
    add(39,0,0,0, 0,0,0, 2,0);
    add(1, 0,0,0, 1,0,0, 1,0);
`else
    add(1, 1,1,0, 0,0,0, 0,1);
    add(19,0,1,0, 0,0,0, 0,1);
    add(1, 0,0,0, 1,0,0, 1,1);
    add(1, 0,0,0, 0,0,0, 1,1);
    // long press held 150 cycles, silent release
    add(1, 1,1,0, 0,0,0, 1,2);
    add(99,0,1,0, 0,0,0, 1,2);
    add(1, 0,1,0, 0,1,0, 2,2);
    add(49,0,1,0, 0,0,0, 2,2);
    add(1, 0,0,0, 0,0,0, 2,2);
    // ticks while pressed are ignored; drop wins over a coincident tick
    add(1, 1,1,0, 0,0,0, 2,3);
    add(1, 1,1,0, 0,0,0, 2,3);
    add(1, 1,0,0, 1,0,0, 1,3);
    // release on the last cycle before long qualifies
    add(1, 1,1,0, 0,0,0, 1,4);
    add(99,0,1,0, 0,0,0, 1,4);
    add(1, 0,0,0, 1,0,0, 1,4);
    for (int i = 5; i <= 9; i++) begin
      add(1, 1,1,0, 0,0,0, 1,(i > 7) ? 7 : i);
      add(1, 0,0,0, 1,0,0, 1,(i > 7) ? 7 : i);
    end
    add(1, 1,1,1, 0,0,0, 1,0);
    add(1, 0,0,0, 1,0,0, 1,0);
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   quiet;
    rst_n = 1'b0; tick = 1'b0; level = 1'b0; clr = 1'b0;
    fill();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.short", short_p, 0);
    chk("rst.long",  long_p,  0);
    chk("rst.dbl",   dbl_p,   0);
    chk("rst.code",  ev_code, 0);
    chk("rst.cnt",   press_cnt, 0);
    rst_n = 1'b1;

    foreach (rows[i]) begin
      quiet = 0;
      for (int c = 0; c < rows[i].n; c++) begin
        tick  = (c == 0) ? rows[i].tick : 1'b0;
        clr   = (c == 0) ? rows[i].clr  : 1'b0;
        level = rows[i].lvl;
        if (c == rows[i].n - 1)
          sb.push_back('{sh: rows[i].sh, lg: rows[i].lg, db: rows[i].db,
                         code: rows[i].code, cnt: rows[i].cnt});
        @(posedge clk);
        #1;
        if (c < rows[i].n - 1) begin
          if (short_p || long_p || dbl_p) quiet++;
        end else begin
          e = sb.pop_front();
          chk($sformatf("row%0d.short", i), short_p,   e.sh);
          chk($sformatf("row%0d.long",  i), long_p,    e.lg);
          chk($sformatf("row%0d.dbl",   i), dbl_p,     e.db);
          chk($sformatf("row%0d.code",  i), ev_code,   e.code);
          chk($sformatf("row%0d.cnt",   i), press_cnt, e.cnt);
        end
      end
      if (rows[i].n > 1) chk($sformatf("row%0d.quiet", i), quiet, 0);
    end
    tick = 1'b0; clr = 1'b0; level = 1'b0;

    // reset pulsed in the middle of a hold
    tick = 1'b1; level = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk("hold.cnt", press_cnt, 1);
    chk("hold.code", ev_code, 1);
    repeat (49) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst.short", short_p, 0);
    chk("midrst.long",  long_p,  0);
    chk("midrst.dbl",   dbl_p,   0);
    chk("midrst.code",  ev_code, 0);
    chk("midrst.cnt",   press_cnt, 0);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    level = 1'b0;
    quiet = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (short_p || long_p || dbl_p) quiet++;
    end
    chk("postrst.quiet", quiet, 0);
    chk("postrst.code",  ev_code, 0);
    chk("postrst.cnt",   press_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Classifies debounced button activity into short-press, long-press and (optionally) double-click events. Sits directly downstream of the switch debouncer. Consumes the debouncer's single-cycle press tick and its debounced level, and produces one-cycle event pulses, a sticky last-event code and a saturating press counter for the application logic.

## Interface
- `LONG_CYCLES`, default 1_000_000: hold duration in clocks that qualifies a long press; must be ≥ 2.
- `GAP_CYCLES`, default 250_000: maximum release-to-second-press gap in clocks for a double click; must be ≥ 2.
- `CNT_W`, default 8: width of the press counter.
- `clk_i`  in  1  system clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `db_tick_i`  in  1  one-cycle pulse from the debouncer on each debounced press.
- `db_level_i`  in  1  debounced switch level; 1 = pressed.
- `clr_cnt_i`  in  1  synchronous clear of `press_cnt_o`.
- `short_o`  out  1  one-cycle short-press pulse.
- `long_o`  out  1  one-cycle long-press pulse.
- `double_o`  out  1  one-cycle double-click pulse; constant 0 when the feature is compiled out.
- `event_code_o`  out  2  last event: 0 none, 1 short, 2 long, 3 double.
- `press_cnt_o`  out  CNT_W  saturating count of accepted presses.

## Operation
- FSM states:
  - `IDLE`: `db_tick_i` → `PRESSED`, timer := 0, press accepted. Otherwise stay.
  - `PRESSED`: timer increments each cycle while `db_level_i` = 1.
    - Timer == `LONG_CYCLES`-1 with level still 1 → emit long, go to `LONG_HELD`.
    - `db_level_i` = 0 before that → go to `WAIT2` with timer := 0 (feature on), or emit short and go to `IDLE` (feature off).
  - `LONG_HELD`: `db_level_i` = 0 → `IDLE`. No event on release.
  - `WAIT2`: timer increments.
    - `db_tick_i` → emit double, press accepted, go to `DBL_HELD`.
    - Else timer == `GAP_CYCLES`-1 → emit short, go to `IDLE`.
  - `DBL_HELD`: `db_level_i` = 0 → `IDLE`. No event on release; a long second press is not classified.
- `db_tick_i` is ignored in `PRESSED`, `LONG_HELD` and `DBL_HELD`. It is not counted.
- On a tick and a level drop in the same cycle in `PRESSED`: the level drop is honoured and the tick ignored.
- In `WAIT2`, a tick on the same cycle as gap expiry counts as a double (tick wins).
- Timer width is `$clog2(max(LONG_CYCLES, GAP_CYCLES))`. The timer never wraps: every terminal value forces a state exit.
- `press_cnt_o`: +1 per accepted press, saturating at 2^CNT_W-1. If `clr_cnt_i` and an accepted press fall on the same cycle, the counter becomes 0 (clear wins).
- `event_code_o` updates on the same edge that asserts an event pulse and holds until the next event.
- At most one event pulse is high in any cycle.

## Timing
- Reset values:
  - state `IDLE`, timer 0.
  - `short_o`, `long_o`, `double_o` = 0.
  - `event_code_o` = 0, `press_cnt_o` = 0.
- All outputs are registered. There are no combinational input→output paths.
- Tick sampled at edge k:
  - state is `PRESSED` after edge k.
  - `long_o` is high in the cycle after edge k+`LONG_CYCLES`, if level stays high through that edge.
- Short, no double: `short_o` is high the cycle after the edge that samples `db_level_i` = 0.
- Short, with double: `short_o` is high the cycle after edge (release edge + `GAP_CYCLES`).
- `double_o` is high the cycle after the edge that samples the second tick.
- `press_cnt_o` updates on the edge that accepts the press.
- Reset asserted mid-operation: everything returns to reset values immediately. A release after deassertion produces no event.

## Configuration
- `BTN_DOUBLE_CLICK_EN` defined: `WAIT2` and `DBL_HELD` exist, and short presses are reported only after the gap expires.
- Not defined: those states are absent, a short press is reported on release, and `double_o` is tied to 0.

## Structure
- `btn_event_pkg` contains:
  - `event_code_t` enum: `EV_NONE`, `EV_SHORT`, `EV_LONG`, `EV_DOUBLE`.
  - `state_t` enum.
  - a function computing the timer width.
- Sub-module `btn_sat_counter`, parameterised by `CNT_W`, with inputs inc and clr and clear priority. It implements the press counter.
- The FSM and timer stay in `btn_event_decoder`.

## Test plan
All scenarios use `LONG_CYCLES`=100, `GAP_CYCLES`=40, `CNT_W`=3.
- Macro off: tick, level high 20 cycles, release → `short_o` for 1 cycle after release; code=1; cnt=1; `double_o` never high.
- Tick, hold 150 cycles → `long_o` for 1 cycle at tick+100 edges; no pulse on release; code=2.
- Macro on: press 20, release, second tick 10 cycles later → `double_o` the cycle after the tick; no `short_o`; code=3; cnt=2.
- Macro on: press 20, release, no tick → `short_o` exactly 40 edges after release; a tick landing on the expiry edge yields `double_o` instead.
- Reset pulsed at cycle 50 of a hold → all outputs 0 at once; the later release gives no event and cnt stays 0.
- Nine presses → cnt saturates at 7; `clr_cnt_i` on the same cycle as a tick in `IDLE` → cnt=0.
